// File: rtl/mem_stage_pkg.sv
// Shared definitions for the memory pipeline stage: FSM encoding and lane constants.
package mem_stage_pkg;

  // Memory-stage FSM: idle (accepting ops) or waiting on the data cache.
  typedef enum logic [0:0] {
    StIdle   = 1'b0,
    StAccess = 1'b1
  } mem_state_e;

  // Width of one byte lane on the data-cache bus.
  localparam int unsigned LANE_W = 8;

  // All four byte lanes enabled.
  localparam logic [3:0] BE_FULL = 4'b1111;

endpackage

// File: rtl/mem_align.sv
// Combinational lane steering between the 32-bit cache bus and the datapath:
// load byte extraction with sign extension, store byte replication and byte enables.
module mem_align
  import mem_stage_pkg::*;
#(
  parameter int unsigned REG_SIZE = 32
) (
  // Load side: lane and size of the outstanding access, raw cache data.
  input  logic [1:0]          ld_lane_i,
  input  logic                ld_is_byte_i,
  input  logic [REG_SIZE-1:0] ld_rdata_i,
  output logic [REG_SIZE-1:0] ld_data_o,
  // Store side: lane, size and direction of the access being issued.
  input  logic [1:0]          st_lane_i,
  input  logic                st_is_byte_i,
  input  logic                st_is_write_i,
  input  logic [REG_SIZE-1:0] st_data_i,
  output logic [REG_SIZE-1:0] st_wdata_o,
  output logic [3:0]          st_be_o
);

  logic [4:0]          ld_shift;
  logic [REG_SIZE-1:0] ld_shifted;
  logic [LANE_W-1:0]   ld_byte;

  assign ld_shift   = {ld_lane_i, 3'b000};
  assign ld_shifted = ld_rdata_i >> ld_shift;
  assign ld_byte    = ld_shifted[LANE_W-1:0];

  // Load path: word passes through, byte is pulled from its lane and sign-extended.
  always_comb begin
    ld_data_o = ld_rdata_i;
    if (ld_is_byte_i) begin
      ld_data_o = {{(REG_SIZE - LANE_W){ld_byte[LANE_W-1]}}, ld_byte};
    end
  end

  // Store path: byte data is copied onto every lane so the enable alone picks the target.
  always_comb begin
    st_wdata_o = st_data_i;
    st_be_o    = BE_FULL;
    if (st_is_byte_i) begin
      st_wdata_o = {(REG_SIZE / LANE_W){st_data_i[LANE_W-1:0]}};
    end
    if (st_is_write_i && st_is_byte_i) begin
      st_be_o = 4'b0001 << st_lane_i;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: issues data-cache requests for loads/stores, stalls upstream
// while an access is outstanding and registers the writeback bundle.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int unsigned REG_SIZE  = 32,
  parameter int unsigned ADDR_SIZE = 32,
  parameter int unsigned REG_ADDR  = 5
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [REG_SIZE-1:0]  alu_result_in,
  input  logic [REG_SIZE-1:0]  data_store_in,
  input  logic                 do_read_in,
  input  logic                 do_write_in,
  input  logic                 is_byte_in,
  input  logic                 memtoreg_in,
  input  logic                 regwrite_in,
  input  logic [REG_ADDR-1:0]  dst_reg_in,
  output logic                 stall,
  output logic                 dc_req,
  output logic                 dc_we,
  output logic [ADDR_SIZE-1:0] dc_addr,
  output logic [REG_SIZE-1:0]  dc_wdata,
  output logic [3:0]           dc_be,
  input  logic [REG_SIZE-1:0]  dc_rdata,
  input  logic                 dc_ack,
  output logic [REG_SIZE-1:0]  wb_data,
  output logic [REG_ADDR-1:0]  wb_dst_reg,
  output logic                 wb_regwrite,
  output logic                 misalign_err
);

  mem_state_e state_q, state_d;

  // Cache request registers.
  logic                 dc_req_q, dc_req_d;
  logic                 dc_we_q, dc_we_d;
  logic [ADDR_SIZE-1:0] dc_addr_q, dc_addr_d;
  logic [REG_SIZE-1:0]  dc_wdata_q, dc_wdata_d;
  logic [3:0]           dc_be_q, dc_be_d;

  // Holding registers for the op in flight (upstream may move on once ack arrives).
  logic [REG_SIZE-1:0]  addr_q, addr_d;
  logic                 is_byte_q, is_byte_d;
  logic                 is_write_q, is_write_d;
  logic                 memtoreg_q, memtoreg_d;
  logic                 regwrite_q, regwrite_d;
  logic [REG_ADDR-1:0]  dst_q, dst_d;

  // Writeback bundle.
  logic [REG_SIZE-1:0]  wb_data_q, wb_data_d;
  logic [REG_ADDR-1:0]  wb_dst_q, wb_dst_d;
  logic                 wb_regwrite_q, wb_regwrite_d;
  logic                 misalign_q, misalign_d;

  logic                 mem_op;
  logic                 misaligned;
  logic                 stall_raw;
  logic [REG_SIZE-1:0]  ld_data;
  logic [REG_SIZE-1:0]  st_wdata;
  logic [3:0]           st_be;

  assign mem_op     = do_read_in | do_write_in;
  assign misaligned = mem_op & ~is_byte_in & (alu_result_in[1:0] != 2'b00);

  mem_align #(
    .REG_SIZE (REG_SIZE)
  ) u_mem_align (
    .ld_lane_i     (addr_q[1:0]),
    .ld_is_byte_i  (is_byte_q),
    .ld_rdata_i    (dc_rdata),
    .ld_data_o     (ld_data),
    .st_lane_i     (alu_result_in[1:0]),
    .st_is_byte_i  (is_byte_in),
    .st_is_write_i (do_write_in),
    .st_data_i     (data_store_in),
    .st_wdata_o    (st_wdata),
    .st_be_o       (st_be)
  );

  // Next-state, request issue and writeback selection.
  always_comb begin
    state_d       = state_q;
    dc_req_d      = dc_req_q;
    dc_we_d       = dc_we_q;
    dc_addr_d     = dc_addr_q;
    dc_wdata_d    = dc_wdata_q;
    dc_be_d       = dc_be_q;
    addr_d        = addr_q;
    is_byte_d     = is_byte_q;
    is_write_d    = is_write_q;
    memtoreg_d    = memtoreg_q;
    regwrite_d    = regwrite_q;
    dst_d         = dst_q;
    wb_data_d     = wb_data_q;
    wb_dst_d      = wb_dst_q;
    wb_regwrite_d = wb_regwrite_q;
    misalign_d    = 1'b0;
    stall_raw     = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (!mem_op) begin
          wb_data_d     = alu_result_in;
          wb_dst_d      = dst_reg_in;
          wb_regwrite_d = regwrite_in;
        end else if (misaligned) begin
          // Dropped without touching the cache; flag it and squash writeback.
          misalign_d    = 1'b1;
          wb_regwrite_d = 1'b0;
        end else begin
          stall_raw     = 1'b1;
          state_d       = StAccess;
          dc_req_d      = 1'b1;
          dc_we_d       = do_write_in;  // read+write together counts as a store
          dc_addr_d     = {alu_result_in[ADDR_SIZE-1:2], 2'b00};
          dc_wdata_d    = st_wdata;
          dc_be_d       = st_be;
          addr_d        = alu_result_in;
          is_byte_d     = is_byte_in;
          is_write_d    = do_write_in;
          memtoreg_d    = memtoreg_in;
          regwrite_d    = regwrite_in;
          dst_d         = dst_reg_in;
          wb_regwrite_d = 1'b0;
        end
      end
      StAccess: begin
        if (!dc_ack) begin
          stall_raw     = 1'b1;
          wb_regwrite_d = 1'b0;
        end else begin
          state_d  = StIdle;
          dc_req_d = 1'b0;
          if (is_write_q) begin
            wb_regwrite_d = 1'b0;
          end else begin
            wb_data_d     = memtoreg_q ? ld_data : addr_q;
            wb_dst_d      = dst_q;
            wb_regwrite_d = regwrite_q;
          end
        end
      end
    endcase
  end

  // Stall is forced low while reset is held so upstream is not frozen by stale state.
  assign stall = stall_raw & ~reset;

  // State, request, holding and writeback registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StIdle;
      dc_req_q      <= 1'b0;
      dc_we_q       <= 1'b0;
      dc_addr_q     <= '0;
      dc_wdata_q    <= '0;
      dc_be_q       <= '0;
      addr_q        <= '0;
      is_byte_q     <= 1'b0;
      is_write_q    <= 1'b0;
      memtoreg_q    <= 1'b0;
      regwrite_q    <= 1'b0;
      dst_q         <= '0;
      wb_data_q     <= '0;
      wb_dst_q      <= '0;
      wb_regwrite_q <= 1'b0;
      misalign_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      dc_req_q      <= dc_req_d;
      dc_we_q       <= dc_we_d;
      dc_addr_q     <= dc_addr_d;
      dc_wdata_q    <= dc_wdata_d;
      dc_be_q       <= dc_be_d;
      addr_q        <= addr_d;
      is_byte_q     <= is_byte_d;
      is_write_q    <= is_write_d;
      memtoreg_q    <= memtoreg_d;
      regwrite_q    <= regwrite_d;
      dst_q         <= dst_d;
      wb_data_q     <= wb_data_d;
      wb_dst_q      <= wb_dst_d;
      wb_regwrite_q <= wb_regwrite_d;
      misalign_q    <= misalign_d;
    end
  end

  assign dc_req       = dc_req_q;
  assign dc_we        = dc_we_q;
  assign dc_addr      = dc_addr_q;
  assign dc_wdata     = dc_wdata_q;
  assign dc_be        = dc_be_q;
  assign wb_data      = wb_data_q;
  assign wb_dst_reg   = wb_dst_q;
  assign wb_regwrite  = wb_regwrite_q;
  assign misalign_err = misalign_q;

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: directed cases plus randomized ops against a
// transaction-level reference model; the bench plays both upstream and data cache.
module tb_mem_stage;

  logic        clk;
  logic        reset;
  logic [31:0] alu_result_in;
  logic [31:0] data_store_in;
  logic        do_read_in;
  logic        do_write_in;
  logic        is_byte_in;
  logic        memtoreg_in;
  logic        regwrite_in;
  logic [4:0]  dst_reg_in;
  logic        stall;
  logic        dc_req;
  logic        dc_we;
  logic [31:0] dc_addr;
  logic [31:0] dc_wdata;
  logic [3:0]  dc_be;
  logic [31:0] dc_rdata;
  logic        dc_ack;
  logic [31:0] wb_data;
  logic [4:0]  wb_dst_reg;
  logic        wb_regwrite;
  logic        misalign_err;

  int n_checks;
  int n_errors;

  mem_stage u_dut (
    .clk           (clk),
    .reset         (reset),
    .alu_result_in (alu_result_in),
    .data_store_in (data_store_in),
    .do_read_in    (do_read_in),
    .do_write_in   (do_write_in),
    .is_byte_in    (is_byte_in),
    .memtoreg_in   (memtoreg_in),
    .regwrite_in   (regwrite_in),
    .dst_reg_in    (dst_reg_in),
    .stall         (stall),
    .dc_req        (dc_req),
    .dc_we         (dc_we),
    .dc_addr       (dc_addr),
    .dc_wdata      (dc_wdata),
    .dc_be         (dc_be),
    .dc_rdata      (dc_rdata),
    .dc_ack        (dc_ack),
    .wb_data       (wb_data),
    .wb_dst_reg    (wb_dst_reg),
    .wb_regwrite   (wb_regwrite),
    .misalign_err  (misalign_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Little-endian byte load with sign extension, or plain word.
  function automatic logic [31:0] load_model(input logic [31:0] rd, input int lane,
                                             input logic byt);
    int unsigned b;
    if (!byt) return rd;
    b = (rd / (32'd1 << (8 * lane))) % 256;
    if (b >= 128) return 32'(b) + 32'hFFFF_FF00;
    return 32'(b);
  endfunction

  // One upstream op; entered and left at a falling edge.
  task automatic run_op(input logic [31:0] addr, input logic [31:0] sdata, input logic rd,
                        input logic wr, input logic byt, input logic m2r, input logic rw,
                        input logic [4:0] dst, input int delay, input logic [31:0] rdata);
    logic        is_mem;
    logic        mis;
    int          lane;
    int          stalls;
    logic [31:0] exp_be;
    logic [31:0] exp_wdata;
    logic [31:0] exp_wb;
    is_mem = rd | wr;
    lane   = int'(addr % 4);
    mis    = is_mem && !byt && lane != 0;
    alu_result_in = addr;
    data_store_in = sdata;
    do_read_in    = rd;
    do_write_in   = wr;
    is_byte_in    = byt;
    memtoreg_in   = m2r;
    regwrite_in   = rw;
    dst_reg_in    = dst;
    dc_rdata      = $urandom;
    // Ack outside ACCESS must be ignored; only legal when no request is being issued.
    dc_ack        = (is_mem && !mis) ? 1'b0 : 1'($urandom_range(0, 1));
    #1;
    check_eq("stall_issue", 32'(stall), 32'(is_mem && !mis));
    @(negedge clk);
    dc_ack = 1'b0;
    if (!is_mem) begin
      check_eq("alu_wb_data", wb_data, addr);
      check_eq("alu_wb_dst", 32'(wb_dst_reg), 32'(dst));
      check_eq("alu_wb_regwrite", 32'(wb_regwrite), 32'(rw));
      check_eq("alu_misalign", 32'(misalign_err), 32'd0);
      check_eq("alu_dc_req", 32'(dc_req), 32'd0);
    end else if (mis) begin
      check_eq("mis_pulse", 32'(misalign_err), 32'd1);
      check_eq("mis_wb_regwrite", 32'(wb_regwrite), 32'd0);
      check_eq("mis_dc_req", 32'(dc_req), 32'd0);
    end else begin
      exp_be    = (wr && byt) ? (32'd1 << lane) : 32'hF;
      exp_wdata = byt ? (sdata % 256) * 32'h0101_0101 : sdata;
      stalls    = 1;
      check_eq("req_dc_req", 32'(dc_req), 32'd1);
      check_eq("req_dc_we", 32'(dc_we), 32'(wr));
      check_eq("req_dc_addr", dc_addr, addr - (addr % 4));
      check_eq("req_dc_be", 32'(dc_be), exp_be);
      if (wr) check_eq("req_dc_wdata", dc_wdata, exp_wdata);
      check_eq("req_misalign", 32'(misalign_err), 32'd0);
      check_eq("req_bubble", 32'(wb_regwrite), 32'd0);
      for (int k = 0; k < delay; k++) begin
        dc_rdata = $urandom;
        #1;
        if (stall) stalls++;
        @(negedge clk);
        check_eq("wait_dc_req", 32'(dc_req), 32'd1);
        check_eq("wait_dc_addr", dc_addr, addr - (addr % 4));
        check_eq("wait_dc_be", 32'(dc_be), exp_be);
        check_eq("wait_bubble", 32'(wb_regwrite), 32'd0);
      end
      dc_ack   = 1'b1;
      dc_rdata = rdata;
      #1;
      if (stall) stalls++;
      check_eq("stall_cycles", 32'(stalls), 32'(delay + 1));
      @(negedge clk);
      dc_ack = 1'b0;
      check_eq("done_dc_req", 32'(dc_req), 32'd0);
      if (wr) begin
        check_eq("st_wb_regwrite", 32'(wb_regwrite), 32'd0);
      end else begin
        exp_wb = m2r ? load_model(rdata, lane, byt) : addr;
        check_eq("ld_wb_data", wb_data, exp_wb);
        check_eq("ld_wb_dst", 32'(wb_dst_reg), 32'(dst));
        check_eq("ld_wb_regwrite", 32'(wb_regwrite), 32'(rw));
      end
    end
  endtask

  task automatic clear_inputs();
    alu_result_in = '0;
    data_store_in = '0;
    do_read_in    = 1'b0;
    do_write_in   = 1'b0;
    is_byte_in    = 1'b0;
    memtoreg_in   = 1'b0;
    regwrite_in   = 1'b0;
    dst_reg_in    = '0;
    dc_rdata      = '0;
    dc_ack        = 1'b0;
  endtask

  initial begin
    logic [31:0] a;
    logic        byt;
    int          kind;
    n_checks = 0;
    n_errors = 0;
    clear_inputs();
    // A pending load on the inputs during reset must not raise stall.
    do_read_in    = 1'b1;
    alu_result_in = 32'h100;
    reset         = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    check_eq("rst_stall", 32'(stall), 32'd0);
    check_eq("rst_dc_req", 32'(dc_req), 32'd0);
    check_eq("rst_dc_addr", dc_addr, 32'd0);
    check_eq("rst_dc_be", 32'(dc_be), 32'd0);
    check_eq("rst_wb_data", wb_data, 32'd0);
    check_eq("rst_wb_regwrite", 32'(wb_regwrite), 32'd0);
    check_eq("rst_misalign", 32'(misalign_err), 32'd0);
    @(negedge clk);
    clear_inputs();
    reset = 1'b0;

    // Directed cases.
    run_op(32'h1234, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5, 0, 32'h0);
    run_op(32'h100, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd7, 3, 32'hDEAD_BEEF);
    run_op(32'h103, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'd8, 1, 32'h80FF_0000);
    run_op(32'h102, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'd9, 0, 32'h80FF_0000);
    run_op(32'h101, 32'h0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 5'd10, 0, 32'h0000_7F00);
    run_op(32'h201, 32'hAB, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 5'd11, 2, 32'h0);
    run_op(32'h204, 32'h1357_9BDF, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd12, 0, 32'h0);
    run_op(32'h102, 32'h0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 5'd13, 0, 32'h0);
    run_op(32'h2468, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd14, 0, 32'h0);
    run_op(32'h308, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd15, 1, 32'h5555_AAAA);

    // Reset while waiting for an ack abandons the request.
    alu_result_in = 32'h300;
    do_read_in    = 1'b1;
    memtoreg_in   = 1'b1;
    regwrite_in   = 1'b1;
    dst_reg_in    = 5'd3;
    @(negedge clk);
    check_eq("rmid_dc_req", 32'(dc_req), 32'd1);
    reset = 1'b1;
    #1;
    check_eq("rmid_stall", 32'(stall), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    clear_inputs();
    #1;
    check_eq("rmid_dc_req_after", 32'(dc_req), 32'd0);
    check_eq("rmid_stall_after", 32'(stall), 32'd0);
    check_eq("rmid_wb_regwrite", 32'(wb_regwrite), 32'd0);
    run_op(32'hCAFE, 32'h0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd21, 0, 32'h0);

    // Randomized ops.
    for (int i = 0; i < 200; i++) begin
      kind = int'($urandom_range(0, 3));
      a    = $urandom;
      byt  = 1'($urandom_range(0, 1));
      if (!byt && $urandom_range(0, 4) != 0) a[1:0] = 2'b00;
      run_op(a, $urandom, kind[0], kind[1], byt, 1'($urandom_range(0, 1)),
             1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
             int'($urandom_range(0, 3)), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory pipeline stage that consumes the execute-stage result bundle and drives the data-cache request/acknowledge interface.
- Bundle: ALU result, store data, read/write/byte flags, memtoreg, destination register, regwrite.
- Performs word and byte loads and stores, and stalls upstream stages while a cache access is outstanding.
- Presents a registered writeback bundle to the writeback stage.

Parameters:
- REG_SIZE, 32, datapath width in bits.
- ADDR_SIZE, 32, data address width.
- REG_ADDR, 5, register-index width.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- alu_result_in  input  REG_SIZE  ALU result; memory address for loads and stores.
- data_store_in  input  REG_SIZE  store data.
- do_read_in  input  1  load request.
- do_write_in  input  1  store request.
- is_byte_in  input  1  byte access (else word).
- memtoreg_in  input  1  writeback selects load data (else ALU result).
- regwrite_in  input  1  writeback enable.
- dst_reg_in  input  REG_ADDR  destination register.
- stall  output  1  combinational; upstream holds its registers (upstream we = ~stall).
- dc_req  output  1  cache request valid.
- dc_we  output  1  1 = store, 0 = load.
- dc_addr  output  ADDR_SIZE  word-aligned address (bits [1:0] = 0).
- dc_wdata  output  REG_SIZE  store data.
- dc_be  output  4  byte enables.
- dc_rdata  input  REG_SIZE  load data, valid with dc_ack.
- dc_ack  input  1  request complete.
- wb_data  output  REG_SIZE  writeback value.
- wb_dst_reg  output  REG_ADDR  writeback register.
- wb_regwrite  output  1  writeback enable.
- misalign_err  output  1  one-cycle pulse on misaligned word access.

Behaviour:
- Reset values: all outputs 0, state IDLE. stall reads 0 during reset.
- Reset mid-access: the outstanding request is abandoned; dc_req is 0 from the next cycle.
- mem_op = do_read_in | do_write_in.
- If do_read_in and do_write_in are both 1, treat as a store.

State IDLE:
- Non-mem op:
  - stall = 0.
  - Next edge: wb_data <= alu_result_in, wb_dst_reg <= dst_reg_in, wb_regwrite <= regwrite_in.
  - Latency 1 cycle.
- Mem op, word access with alu_result_in[1:0] != 0:
  - stall = 0; no request issued.
  - Next edge: misalign_err <= 1, wb_regwrite <= 0.
- Mem op otherwise:
  - stall = 1.
  - Next edge: capture address, lane, data, flags and dst into holding registers.
  - Drive dc_req <= 1 and dc_we, dc_addr, dc_wdata, dc_be; wb_regwrite <= 0 (bubble); go to ACCESS.

State ACCESS:
- dc_ack = 0: stall = 1, dc_req stays 1, all dc_* outputs held stable, wb_regwrite <= 0 each edge.
- dc_ack = 1: stall = 0. Next edge:
  - dc_req <= 0.
  - Writeback bundle loaded:
    - Loads: wb_data = memtoreg ? aligned load data : held address; wb_regwrite = held regwrite.
    - Stores: wb_regwrite = 0.
  - Go to IDLE.
- Minimum mem-op latency is 2 cycles (ack in the first ACCESS cycle), i.e. 1 stall bubble.

Handshake rules:
- dc_ack is ignored outside ACCESS.
- The cache must not ack in the same cycle dc_req rises from IDLE (dc_req is registered).
- No timeout: the block waits indefinitely for dc_ack.

Alignment (little-endian):
- Byte load: lane = addr[1:0]; wb_data = sign-extended dc_rdata[8*lane+7 : 8*lane].
- Word load: dc_rdata passes through unchanged.
- Byte store: dc_wdata = data_store[7:0] replicated to all 4 lanes; dc_be = 1 << lane.
- Word store: dc_be = 4'b1111.
- Loads: dc_be = 4'b1111.

Decomposition:
- Shared package holds:
  - state encoding (IDLE = 0, ACCESS = 1);
  - byte-lane width constant (8);
  - BE_FULL = 4'b1111.
- One combinational sub-module, mem_align:
  - load-lane extract and sign-extend;
  - store-lane replication and dc_be generation.
- The FSM, holding registers and writeback registers stay in mem_stage.

Test Plan:
- Non-mem op, alu_result_in = 0x1234, regwrite = 1, dst = 5 -> next cycle wb_data = 0x1234, wb_dst_reg = 5, wb_regwrite = 1; stall never 1.
- Word load at 0x100, dc_ack 3 cycles after dc_req, dc_rdata = 0xDEADBEEF, memtoreg = 1, dst = 7:
  - stall high 4 cycles; dc_addr = 0x100, dc_be = 0xF.
  - Then wb_data = 0xDEADBEEF, wb_regwrite = 1.
- Byte load at 0x103, dc_rdata = 0x80FF0000 -> wb_data = 0xFFFFFF80.
- Byte load at 0x102, same dc_rdata -> wb_data = 0xFFFFFFFF.
- Byte store at 0x201, data_store = 0x000000AB:
  - dc_addr = 0x200, dc_wdata = 0xABABABAB, dc_be = 0x2, dc_we = 1.
  - wb_regwrite = 0.
- Word load at 0x102 -> misalign_err pulses once, dc_req stays 0, wb_regwrite = 0, stall = 0.
- Reset asserted during ACCESS with dc_ack = 0 -> next cycle dc_req = 0, stall = 0, state IDLE; a following non-mem op completes in 1 cycle.
